// File: rtl/ahb_lite_two_master_arb.sv
// Two-master AHB-Lite arbiter with a holding register per master.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin instead of fixed M0 priority.
module ahb_lite_two_master_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDRM0,
  input  logic [1:0]        HTRANSM0,
  input  logic              HWRITEM0,
  input  logic              HMASTLOCKM0,
  input  logic [2:0]        HSIZEM0,
  input  logic [2:0]        HBURSTM0,
  input  logic [3:0]        HPROTM0,
  input  logic [DATA_W-1:0] HWDATAM0,
  output logic [DATA_W-1:0] HRDATAM0,
  output logic              HREADYM0,
  output logic              HRESPM0,
  input  logic [ADDR_W-1:0] HADDRM1,
  input  logic [1:0]        HTRANSM1,
  input  logic              HWRITEM1,
  input  logic              HMASTLOCKM1,
  input  logic [2:0]        HSIZEM1,
  input  logic [2:0]        HBURSTM1,
  input  logic [3:0]        HPROTM1,
  input  logic [DATA_W-1:0] HWDATAM1,
  output logic [DATA_W-1:0] HRDATAM1,
  output logic              HREADYM1,
  output logic              HRESPM1,
  output logic [ADDR_W-1:0] HADDRS,
  output logic [1:0]        HTRANSS,
  output logic              HWRITES,
  output logic [2:0]        HSIZES,
  output logic [2:0]        HBURSTS,
  output logic [3:0]        HPROTS,
  output logic              HMASTLOCKS,
  output logic [DATA_W-1:0] HWDATAS,
  input  logic [DATA_W-1:0] HRDATAS,
  input  logic              HREADYS,
  input  logic              HRESPS,
  output logic              HMASTERS
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } ctl_t;

  typedef enum logic [1:0] {
    DP_NONE,
    DP_M0,
    DP_M1
  } dp_t;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  ctl_t live0, live1;
  ctl_t hold0, hold1;
  ctl_t src0, src1;
  ctl_t cur_ctl, last_ctl;
  logic [1:0] tr0, tr1;
  logic [1:0] cur_trans, last_trans;
  logic pend0, pend1;
  logic req0, req1, any_req;
  logic win, rr_pick;
  logic lock_q, lock_mst, lock_hit;
  logic issue0, issue1;
  logic cap0, cap1;
  logic cur_mst, last_mst;
  dp_t  dp_owner;

  assign live0 = {HADDRM0, HWRITEM0, HSIZEM0,
                  HBURSTM0, HPROTM0, HMASTLOCKM0};
  assign live1 = {HADDRM1, HWRITEM1, HSIZEM1,
                  HBURSTM1, HPROTM1, HMASTLOCKM1};

  // A held transfer always restarts as NONSEQ
  assign src0 = pend0 ? hold0 : live0;
  assign src1 = pend1 ? hold1 : live1;
  assign tr0  = pend0 ? NONSEQ : HTRANSM0;
  assign tr1  = pend1 ? NONSEQ : HTRANSM1;

  assign req0 = HRESETn & HREADYS & (pend0 | HTRANSM0[1]);
  assign req1 = HRESETn & HREADYS & (pend1 | HTRANSM1[1]);
  assign any_req  = req0 | req1;
  assign lock_hit = lock_q & (lock_mst ? req1 : req0);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  assign rr_pick = ~last_gnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_gnt <= 1'b1;
    end else if (HREADYS && any_req) begin
      last_gnt <= win;
    end
  end
`else
  assign rr_pick = 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    if (lock_hit) begin
      win = lock_mst;
    end else if (req0 && req1) begin
      win = rr_pick;
    end else begin
      win = req1;
    end
  end

  assign issue0 = any_req & ~win;
  assign issue1 = any_req & win;

  assign cur_ctl   = any_req ? (win ? src1 : src0) : last_ctl;
  assign cur_trans = any_req ? (win ? tr1 : tr0) : IDLE;
  assign cur_mst   = any_req ? win : last_mst;

  // Data-phase owner's next address is not held during its own waits
  assign cap0 = ~pend0 & HTRANSM0[1] & ~issue0
              & (HREADYS | (dp_owner != DP_M0));
  assign cap1 = ~pend1 & HTRANSM1[1] & ~issue1
              & (HREADYS | (dp_owner != DP_M1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (cap0) begin
        pend0 <= 1'b1;
        hold0 <= live0;
      end else if (issue0) begin
        pend0 <= 1'b0;
      end
      if (cap1) begin
        pend1 <= 1'b1;
        hold1 <= live1;
      end else if (issue1) begin
        pend1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_ctl   <= '0;
      last_trans <= IDLE;
      last_mst   <= 1'b0;
      lock_q     <= 1'b0;
      lock_mst   <= 1'b0;
      dp_owner   <= DP_NONE;
    end else if (HREADYS) begin
      last_ctl   <= cur_ctl;
      last_trans <= cur_trans;
      last_mst   <= cur_mst;
      lock_q     <= any_req & cur_ctl.lock;
      lock_mst   <= win;
      if (!any_req) begin
        dp_owner <= DP_NONE;
      end else if (win) begin
        dp_owner <= DP_M1;
      end else begin
        dp_owner <= DP_M0;
      end
    end
  end

  assign {HADDRS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS} =
    HREADYS ? cur_ctl : last_ctl;
  assign HTRANSS  = HREADYS ? cur_trans : last_trans;
  assign HMASTERS = HREADYS ? cur_mst : last_mst;

  assign HREADYM0 = pend0 ? 1'b0 : HREADYS;
  assign HREADYM1 = pend1 ? 1'b0 : HREADYS;
  assign HRESPM0  = (dp_owner == DP_M0) & HRESPS;
  assign HRESPM1  = (dp_owner == DP_M1) & HRESPS;
  assign HRDATAM0 = HRDATAS;
  assign HRDATAM1 = HRDATAS;

  always_comb begin
    HWDATAS = '0;
    unique case (dp_owner)
      DP_M0:   HWDATAS = HWDATAM0;
      DP_M1:   HWDATAS = HWDATAM1;
      default: HWDATAS = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_two_master_arb.sv
// Bench for ahb_lite_two_master_arb: vector table, corner sequences,
// and random traffic against a transfer-level reference model.
module tb_ahb_lite_two_master_arb;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [31:0] HADDRM0, HADDRM1, HWDATAM0, HWDATAM1;
  logic [1:0]  HTRANSM0, HTRANSM1;
  logic        HWRITEM0, HWRITEM1, HMASTLOCKM0, HMASTLOCKM1;
  logic [2:0]  HSIZEM0, HSIZEM1, HBURSTM0, HBURSTM1;
  logic [3:0]  HPROTM0, HPROTM1;
  logic [31:0] HRDATAM0, HRDATAM1;
  logic        HREADYM0, HREADYM1, HRESPM0, HRESPM1;
  logic [31:0] HADDRS, HWDATAS, HRDATAS;
  logic [1:0]  HTRANSS;
  logic        HWRITES, HMASTLOCKS, HREADYS, HRESPS, HMASTERS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;

  ahb_lite_two_master_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDRM0(HADDRM0), .HTRANSM0(HTRANSM0), .HWRITEM0(HWRITEM0),
    .HMASTLOCKM0(HMASTLOCKM0), .HSIZEM0(HSIZEM0), .HBURSTM0(HBURSTM0),
    .HPROTM0(HPROTM0), .HWDATAM0(HWDATAM0), .HRDATAM0(HRDATAM0),
    .HREADYM0(HREADYM0), .HRESPM0(HRESPM0),
    .HADDRM1(HADDRM1), .HTRANSM1(HTRANSM1), .HWRITEM1(HWRITEM1),
    .HMASTLOCKM1(HMASTLOCKM1), .HSIZEM1(HSIZEM1), .HBURSTM1(HBURSTM1),
    .HPROTM1(HPROTM1), .HWDATAM1(HWDATAM1), .HRDATAM1(HRDATAM1),
    .HREADYM1(HREADYM1), .HRESPM1(HRESPM1),
    .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HWDATAS(HWDATAS), .HRDATAS(HRDATAS),
    .HREADYS(HREADYS), .HRESPS(HRESPS), .HMASTERS(HMASTERS)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lk;
  } xfer_t;

  bit          h[2];
  xfer_t       held[2];
  int          dp, lk_own, lastg, m_win, last_m, e_m;
  xfer_t       last_x, e_x;
  logic [1:0]  last_tr, e_tr;
  logic        e_rdy[2], e_rsp[2];
  logic [31:0] e_wd;

  function automatic xfer_t live_x(int m);
    xfer_t x;
    if (m == 0) begin
      x.addr = HADDRM0; x.wr = HWRITEM0; x.size = HSIZEM0;
      x.burst = HBURSTM0; x.prot = HPROTM0; x.lk = HMASTLOCKM0;
    end else begin
      x.addr = HADDRM1; x.wr = HWRITEM1; x.size = HSIZEM1;
      x.burst = HBURSTM1; x.prot = HPROTM1; x.lk = HMASTLOCKM1;
    end
    return x;
  endfunction

  function automatic logic [1:0] live_tr(int m);
    return (m == 0) ? HTRANSM0 : HTRANSM1;
  endfunction

  task automatic model_reset();
    h[0] = 0; h[1] = 0;
    dp = -1; lk_own = -1; lastg = 1; m_win = -1;
    last_x = '{32'h0, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0};
    last_tr = 2'b00; last_m = 0;
  endtask

  task automatic model_eval();
    bit want[2];
    int pref;
    logic [1:0] t;
    for (int m = 0; m < 2; m++) begin
      t = live_tr(m);
      e_rdy[m] = h[m] ? 1'b0 : HREADYS;
      want[m] = HRESETn && HREADYS && (h[m] || t[1]);
      e_rsp[m] = (dp == m) ? HRESPS : 1'b0;
    end
    m_win = -1;
    if (lk_own >= 0 && want[lk_own]) m_win = lk_own;
    else begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
      pref = 1 - lastg;
`else
      pref = 0;
`endif
      if (want[pref]) m_win = pref;
      else if (want[1-pref]) m_win = 1 - pref;
    end
    if (!HREADYS) begin
      e_x = last_x; e_tr = last_tr; e_m = last_m;
    end else if (m_win < 0) begin
      e_x = last_x; e_tr = 2'b00; e_m = last_m;
    end else begin
      e_x  = h[m_win] ? held[m_win] : live_x(m_win);
      e_tr = h[m_win] ? 2'b10 : live_tr(m_win);
      e_m  = m_win;
    end
    e_wd = (dp < 0) ? 32'h0 : (dp == 0 ? HWDATAM0 : HWDATAM1);
  endtask

  task automatic model_update();
    logic [1:0] t;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      t = live_tr(m);
      if (m_win == m && h[m]) h[m] = 0;
      else if (!h[m] && t[1] && m_win != m && (HREADYS || dp != m)) begin
        h[m] = 1;
        held[m] = live_x(m);
      end
    end
    if (HREADYS) begin
      last_x = e_x; last_tr = e_tr; last_m = e_m;
      dp = m_win;
      lk_own = (m_win >= 0 && e_x.lk) ? m_win : -1;
      if (m_win >= 0) lastg = m_win;
    end
  endtask

  task automatic model_check();
    model_eval();
    chk("m_trans", HTRANSS, e_tr);
    chk("m_addr", HADDRS, e_x.addr);
    chk("m_write", HWRITES, e_x.wr);
    chk("m_size", HSIZES, e_x.size);
    chk("m_burst", HBURSTS, e_x.burst);
    chk("m_prot", HPROTS, e_x.prot);
    chk("m_lock", HMASTLOCKS, e_x.lk);
    chk("m_master", HMASTERS, e_m);
    chk("m_ready0", HREADYM0, e_rdy[0]);
    chk("m_ready1", HREADYM1, e_rdy[1]);
    chk("m_resp0", HRESPM0, e_rsp[0]);
    chk("m_resp1", HRESPM1, e_rsp[1]);
    chk("m_wdata", HWDATAS, e_wd);
    chk("m_rdata0", HRDATAM0, HRDATAS);
    chk("m_rdata1", HRDATAM1, HRDATAS);
  endtask

  task automatic half();
    @(negedge HCLK);
    model_check();
  endtask

  task automatic adv();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic set_m(int m, logic [1:0] t, logic [31:0] a,
                       logic w, logic lk);
    if (m == 0) begin
      HTRANSM0 = t; HADDRM0 = a; HWRITEM0 = w; HMASTLOCKM0 = lk;
    end else begin
      HTRANSM1 = t; HADDRM1 = a; HWRITEM1 = w; HMASTLOCKM1 = lk;
    end
  endtask

  task automatic idle_all();
    set_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    set_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    HSIZEM0 = 3'd2; HSIZEM1 = 3'd2;
    HBURSTM0 = 3'd0; HBURSTM1 = 3'd0;
    HPROTM0 = 4'd3; HPROTM1 = 4'd3;
    HREADYS = 1'b1; HRESPS = 1'b0; HRDATAS = 32'h0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    idle_all();
    model_reset();
    half();
    chk("rst_trans", HTRANSS, 2'b00);
    chk("rst_ready1", HREADYM1, 1'b1);
    adv();
    HRESETn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] t0; logic [31:0] a0;
    logic [1:0] t1; logic [31:0] a1;
    logic w1; logic [31:0] wd1;
    logic rdy; logic rsp;
    logic [1:0] e_tr; logic [31:0] e_a; logic e_m;
    logic e_r0; logic e_r1; logic [31:0] e_wd;
    logic e_p0; logic e_p1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    for (int i = 0; i < 10; i++)
      tbl[i] = '{2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0,
                 2'd0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 32'h100, 2'd2, 32'h200, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1,
                2'd2, 32'h100, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 32'h100, 2'd0, 32'h200, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1,
                2'd2, 32'h200, 1'b1, 1'b1, 1'b0, 32'h11110000, 1'b1, 1'b0};
    tbl[12] = '{2'd0, 32'h0, 2'd0, 32'h200, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1,
                2'd0, 32'h200, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
    tbl[13] = '{2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
                2'd0, 32'h200, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};

    HWDATAM0 = 32'h11110000;
    HWDATAM1 = 32'h0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      set_m(0, tbl[i].t0, tbl[i].a0, 1'b0, 1'b0);
      set_m(1, tbl[i].t1, tbl[i].a1, tbl[i].w1, 1'b0);
      HWDATAM1 = tbl[i].wd1;
      HREADYS = tbl[i].rdy;
      HRESPS = tbl[i].rsp;
      half();
      chk("tbl_trans", HTRANSS, tbl[i].e_tr);
      chk("tbl_addr", HADDRS, tbl[i].e_a);
      chk("tbl_master", HMASTERS, tbl[i].e_m);
      chk("tbl_ready0", HREADYM0, tbl[i].e_r0);
      chk("tbl_ready1", HREADYM1, tbl[i].e_r1);
      chk("tbl_wdata", HWDATAS, tbl[i].e_wd);
      chk("tbl_resp0", HRESPM0, tbl[i].e_p0);
      chk("tbl_resp1", HRESPM1, tbl[i].e_p1);
      adv();
    end
    HRESPS = 1'b0;

    // slave wait states with a late M1 request
    set_m(0, 2'b10, 32'h40, 1'b0, 1'b0);
    half();
    chk("ws_issue_addr", HADDRS, 32'h40);
    chk("ws_issue_mst", HMASTERS, 1'b0);
    adv();
    set_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    set_m(1, 2'b10, 32'h80, 1'b1, 1'b0);
    HREADYS = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("ws_frozen_addr", HADDRS, 32'h40);
      chk("ws_frozen_trans", HTRANSS, 2'b10);
      chk("ws_ready0", HREADYM0, 1'b0);
      chk("ws_ready1", HREADYM1, 1'b0);
      adv();
    end
    HREADYS = 1'b1;
    half();
    chk("ws_held_addr", HADDRS, 32'h80);
    chk("ws_held_mst", HMASTERS, 1'b1);
    chk("ws_held_trans", HTRANSS, 2'b10);
    adv();
    set_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    HWDATAM1 = 32'h80808080;
    half();
    chk("ws_wdata", HWDATAS, 32'h80808080);
    chk("ws_ready1_back", HREADYM1, 1'b1);
    adv();

    // locked M1 pair beats higher-priority M0
    set_m(1, 2'b10, 32'h300, 1'b1, 1'b1);
    half();
    chk("lk_addr0", HADDRS, 32'h300);
    adv();
    set_m(1, 2'b11, 32'h304, 1'b1, 1'b1);
    set_m(0, 2'b10, 32'h0, 1'b0, 1'b0);
    half();
    chk("lk_addr1", HADDRS, 32'h304);
    chk("lk_mst1", HMASTERS, 1'b1);
    adv();
    set_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    half();
    chk("lk_m0_addr", HADDRS, 32'h0);
    chk("lk_m0_mst", HMASTERS, 1'b0);
    chk("lk_m0_ready", HREADYM0, 1'b0);
    adv();
    set_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    half();
    chk("lk_idle", HTRANSS, 2'b00);
    adv();

    // both masters streaming
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_m(0, 2'b10, 32'h1000 + 4 * i, 1'b0, 1'b0);
      set_m(1, 2'b10, 32'h2000 + 4 * i, 1'b1, 1'b0);
      half();
`ifdef AHB_ARB_ROUND_ROBIN_EN
      chk("stream_mst", HMASTERS, i % 2);
`else
      chk("stream_mst", HMASTERS, 1'b0);
`endif
      adv();
    end
    idle_all();
    for (int i = 0; i < 3; i++) begin
      half();
      adv();
    end

    // reset while M1 is held and M0 owns the data phase
    do_reset();
    HWDATAM0 = 32'h55;
    set_m(0, 2'b10, 32'h500, 1'b1, 1'b0);
    set_m(1, 2'b10, 32'h600, 1'b0, 1'b0);
    half();
    chk("rr_pre_mst", HMASTERS, 1'b0);
    adv();
    set_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    HRESPS = 1'b1;
    #2;
    chk("pre_ready1", HREADYM1, 1'b0);
    chk("pre_resp0", HRESPM0, 1'b1);
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("ar_trans", HTRANSS, 2'b00);
    chk("ar_master", HMASTERS, 1'b0);
    chk("ar_ready0", HREADYM0, 1'b1);
    chk("ar_ready1", HREADYM1, 1'b1);
    chk("ar_resp0", HRESPM0, 1'b0);
    chk("ar_wdata", HWDATAS, 32'h0);
    half();
    adv();
    HRESETn = 1'b1;
    HRESPS = 1'b0;
    set_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    set_m(0, 2'b10, 32'h700, 1'b0, 1'b0);
    half();
    chk("post_trans", HTRANSS, 2'b10);
    chk("post_addr", HADDRS, 32'h700);
    adv();
    set_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      half();
      chk("no_stale_trans", HTRANSS, 2'b00);
      chk("no_stale_mst", HMASTERS, 1'b0);
      adv();
    end

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        set_m(m, 2'($urandom_range(0, 3)), $urandom & 32'hFFFC,
              1'($urandom % 2), 1'($urandom % 5 == 0));
      HSIZEM0 = 3'($urandom % 3); HSIZEM1 = 3'($urandom % 3);
      HBURSTM0 = 3'($urandom); HBURSTM1 = 3'($urandom);
      HPROTM0 = 4'($urandom); HPROTM1 = 4'($urandom);
      HWDATAM0 = $urandom; HWDATAM1 = $urandom;
      HRDATAS = $urandom;
      HREADYS = ($urandom % 4 != 0);
      HRESPS = 1'($urandom % 2);
      half();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
